// File: rtl/ff_calc.sv
// ff_calc: token-stream expression evaluator with two-level precedence.
// Operands and operators arrive one at a time through a valid strobe.
// Each accepted token is acknowledged by a one-cycle calc_ready pulse.
// The '=' token publishes the running result and halts the block until reset.
module ff_calc (
  input  logic        clock,
  input  logic        reset,
  input  logic        token_valid,
  input  logic [31:0] token_data,
  output logic        calc_ready,
  output logic        is_equal,
  output logic [31:0] calc_answer,
  output logic        calc_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TERM,
    S_DIV,
    S_SUM,
    S_ACK,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    T_NONE,
    T_MUL,
    T_DIV
  } term_t;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  localparam logic [3:0] OP_EQ  = 4'hE;

  state_t      state;
  term_t       term_op;
  logic [31:0] cur;
  logic [31:0] term_acc;
  logic [31:0] sum_acc;
  logic        sum_sub;      // 0 = ADD, 1 = SUB
  logic        expect_num;
  logic [3:0]  opc;          // latched operator code
  logic        tok_err;      // current token is erroneous: no arithmetic
  logic        eq_tok;       // current token is a valid '='

  // Restoring divider state (works on magnitudes)
  logic [31:0] div_rem;
  logic [31:0] div_quo;
  logic [31:0] div_dvs;
  logic        div_neg;
  logic [5:0]  div_cnt;

  logic [31:0] prod_lo;
  logic [31:0] sum_next;
  logic [31:0] term_abs;
  logic [31:0] cur_abs;
  logic [31:0] div_shift;
  logic [32:0] div_trial;
  logic        op_code_ok;

  // Low half of the product is the same for signed and unsigned operands
  assign prod_lo    = term_acc * cur;
  assign sum_next   = sum_sub ? (sum_acc - cur) : (sum_acc + cur);
  assign term_abs   = term_acc[31] ? (32'd0 - term_acc) : term_acc;
  assign cur_abs    = cur[31] ? (32'd0 - cur) : cur;
  // Remainder stays below the divisor (<= 2^31), so the shifted value fits 32 bits
  assign div_shift  = {div_rem[30:0], div_quo[31]};
  assign div_trial  = {1'b0, div_shift} - {1'b0, div_dvs};
  assign op_code_ok = (token_data[3:0] >= OP_ADD) && (token_data[3:0] <= OP_EQ);

  // Main controller: token sampling, arithmetic sequencing and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      term_op     <= T_NONE;
      cur         <= 32'd0;
      term_acc    <= 32'd0;
      sum_acc     <= 32'd0;
      sum_sub     <= 1'b0;
      expect_num  <= 1'b1;
      opc         <= 4'd0;
      tok_err     <= 1'b0;
      eq_tok      <= 1'b0;
      div_rem     <= 32'd0;
      div_quo     <= 32'd0;
      div_dvs     <= 32'd0;
      div_neg     <= 1'b0;
      div_cnt     <= 6'd0;
      calc_ready  <= 1'b0;
      is_equal    <= 1'b0;
      calc_answer <= 32'd0;
      calc_error  <= 1'b0;
    end else begin
      calc_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (token_valid) begin
            if (!token_data[31]) begin
              cur        <= token_data;
              expect_num <= 1'b0;
              tok_err    <= 1'b0;
              eq_tok     <= 1'b0;
              state      <= S_ACK;
              calc_ready <= 1'b1;
            end else if (expect_num || !op_code_ok) begin
              // Erroneous operator still takes the normal 3-cycle path,
              // but TERM/SUM leave every arithmetic register untouched
              opc        <= token_data[3:0];
              calc_error <= 1'b1;
              tok_err    <= 1'b1;
              eq_tok     <= 1'b0;
              state      <= S_TERM;
            end else begin
              opc        <= token_data[3:0];
              expect_num <= 1'b1;
              tok_err    <= 1'b0;
              eq_tok     <= (token_data[3:0] == OP_EQ);
              if (term_op == T_DIV) begin
                div_rem <= 32'd0;
                div_quo <= term_abs;
                div_dvs <= cur_abs;
                div_neg <= term_acc[31] ^ cur[31];
                div_cnt <= 6'd0;
                state   <= S_DIV;
              end else begin
                state <= S_TERM;
              end
            end
          end
        end

        S_TERM: begin
          if (!tok_err && (term_op == T_MUL)) begin
            cur <= prod_lo;
          end
          state <= S_SUM;
        end

        S_DIV: begin
          if (div_cnt != 6'd32) begin
            if (!div_trial[32]) begin
              div_rem <= div_trial[31:0];
              div_quo <= {div_quo[30:0], 1'b1};
            end else begin
              div_rem <= div_shift;
              div_quo <= {div_quo[30:0], 1'b0};
            end
            div_cnt <= div_cnt + 6'd1;
          end else begin
            // Sign fix; 0x80000000 / -1 wraps naturally to 0x80000000
            if (div_dvs == 32'd0) begin
              cur        <= 32'd0;
              calc_error <= 1'b1;
            end else begin
              cur <= div_neg ? (32'd0 - div_quo) : div_quo;
            end
            state <= S_SUM;
          end
        end

        S_SUM: begin
          if (!tok_err) begin
            case (opc)
              OP_MUL: begin
                term_acc <= cur;
                term_op  <= T_MUL;
              end
              OP_DIV: begin
                term_acc <= cur;
                term_op  <= T_DIV;
              end
              default: begin
                sum_acc <= sum_next;
                term_op <= T_NONE;
                sum_sub <= (opc == OP_SUB);
                if (opc == OP_EQ) begin
                  calc_answer <= sum_next;
                end
              end
            endcase
          end
          if (eq_tok) begin
            is_equal <= 1'b1;
          end
          calc_ready <= 1'b1;
          state      <= S_ACK;
        end

        S_ACK: begin
          state <= eq_tok ? S_HALT : S_IDLE;
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_calc.sv
// Scoreboard bench for ff_calc: the driver pushes the expected ack record,
// an independent monitor pops and compares on every calc_ready pulse.
module tb_ff_calc;

  logic        clock;
  logic        reset;
  logic        token_valid;
  logic [31:0] token_data;
  logic        calc_ready;
  logic        is_equal;
  logic [31:0] calc_answer;
  logic        calc_error;

  localparam logic [31:0] T_ADD = 32'h8000000A;
  localparam logic [31:0] T_SUB = 32'h8000000B;
  localparam logic [31:0] T_MUL = 32'h8000000C;
  localparam logic [31:0] T_DIV = 32'h8000000D;
  localparam logic [31:0] T_EQ  = 32'h8000000E;

  typedef struct {
    logic [31:0] tok;
    int          c0;
    int          lat;
    logic        eq;
    logic [31:0] ans;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  logic prev_ready = 1'b0;

  ff_calc dut (
    .clock       (clock),
    .reset       (reset),
    .token_valid (token_valid),
    .token_data  (token_data),
    .calc_ready  (calc_ready),
    .is_equal    (is_equal),
    .calc_answer (calc_answer),
    .calc_error  (calc_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every acknowledge against the oldest expected record
  always @(negedge clock) begin
    if (reset === 1'b1 && calc_ready === 1'b1) begin
      chk("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("ack tok=%h lat=%0d ans=%h eq=%b err=%b", e.tok, cycle - e.c0 + 1,
                 calc_answer, is_equal, calc_error);
        chk("ack_latency", cycle - e.c0 + 1, e.lat);
        chk("is_equal", {31'd0, is_equal}, {31'd0, e.eq});
        chk("calc_answer", calc_answer, e.ans);
        chk("calc_error", {31'd0, calc_error}, {31'd0, e.err});
      end
    end
    prev_ready <= calc_ready;
  end

  // Issue one token and wait (bounded) for its acknowledge
  task automatic send(input logic [31:0] tok, input int lat, input logic eq,
                      input logic [31:0] ans, input logic err);
    exp_t e;
    bit   got;
    @(negedge clock);
    token_valid = 1'b1;
    token_data  = tok;
    e.tok = tok; e.c0 = cycle + 1; e.lat = lat; e.eq = eq; e.ans = ans; e.err = err;
    sb.push_back(e);
    @(negedge clock);
    token_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (calc_ready === 1'b1) got = 1'b1;
      else @(negedge clock);
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  // Strobe a token without waiting for any acknowledge
  task automatic strobe(input logic [31:0] tok);
    @(negedge clock);
    token_valid = 1'b1;
    token_data  = tok;
    @(negedge clock);
    token_valid = 1'b0;
  endtask

  // Assert reset away from the clock edge and check outputs clear at once
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, calc_ready}, 32'd0);
    chk("rst_is_equal", {31'd0, is_equal}, 32'd0);
    chk("rst_answer", calc_answer, 32'd0);
    chk("rst_error", {31'd0, calc_error}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    token_valid = 1'b0;
    token_data  = 32'd0;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // 12 + 3 * 4 = 24
    do_reset();
    send(32'd12, 1, 0, 32'd0, 0);
    send(T_ADD,  3, 0, 32'd0, 0);
    send(32'd3,  1, 0, 32'd0, 0);
    send(T_MUL,  3, 0, 32'd0, 0);
    send(32'd4,  1, 0, 32'd0, 0);
    send(T_EQ,   3, 1, 32'd24, 0);
    // Halted: a further token is ignored, outputs hold
    strobe(32'd9);
    repeat (10) @(negedge clock);
    chk("halt_answer", calc_answer, 32'd24);
    chk("halt_is_equal", {31'd0, is_equal}, 32'd1);
    chk("halt_error", {31'd0, calc_error}, 32'd0);

    // 100 / 7 - 2 = 12, '-' pays the divider latency
    do_reset();
    send(32'd100, 1, 0, 32'd0, 0);
    send(T_DIV,   3, 0, 32'd0, 0);
    send(32'd7,   1, 0, 32'd0, 0);
    send(T_SUB,  35, 0, 32'd0, 0);
    send(32'd2,   1, 0, 32'd0, 0);
    send(T_EQ,    3, 1, 32'd12, 0);

    // 3 - 10 = -7
    do_reset();
    send(32'd3,  1, 0, 32'd0, 0);
    send(T_SUB,  3, 0, 32'd0, 0);
    send(32'd10, 1, 0, 32'd0, 0);
    send(T_EQ,   3, 1, 32'hFFFFFFF9, 0);

    // 0x7FFFFFFF + 1 wraps
    do_reset();
    send(32'h7FFFFFFF, 1, 0, 32'd0, 0);
    send(T_ADD,        3, 0, 32'd0, 0);
    send(32'd1,        1, 0, 32'd0, 0);
    send(T_EQ,         3, 1, 32'h80000000, 0);

    // 5 / 0 = 0 with error
    do_reset();
    send(32'd5, 1, 0, 32'd0, 0);
    send(T_DIV, 3, 0, 32'd0, 0);
    send(32'd0, 1, 0, 32'd0, 0);
    send(T_EQ, 35, 1, 32'd0, 1);

    // Operator first: error, normal 3-cycle ack
    do_reset();
    send(T_ADD, 3, 0, 32'd0, 1);
    // Then start a division and reset during it
    send(32'd100, 1, 0, 32'd0, 1);
    send(T_DIV,   3, 0, 32'd0, 1);
    send(32'd7,   1, 0, 32'd0, 1);
    strobe(T_SUB);
    repeat (9) @(negedge clock);
    do_reset();
    send(32'd2, 1, 0, 32'd0, 0);
    send(T_EQ,  3, 1, 32'd2, 0);

    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
